// File: rtl/lap_timer_pkg.sv
// Shared types for the lap timer.
//   timer_state_t : top-level operating state
//   cmd_t         : resolved user command, encoded so a larger value wins
//   resolve_cmd() : applies clear > stop > start > edit to the raw pulses
package lap_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

  // Encoding order equals priority order: only the winner of a cycle acts.
  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_EDIT  = 3'd1,
    CMD_START = 3'd2,
    CMD_STOP  = 3'd3,
    CMD_CLEAR = 3'd4
  } cmd_t;

  function automatic cmd_t resolve_cmd(input logic clear, input logic stop,
                                       input logic start, input logic edit);
    cmd_t c;
    if (clear)      c = CMD_CLEAR;
    else if (stop)  c = CMD_STOP;
    else if (start) c = CMD_START;
    else if (edit)  c = CMD_EDIT;
    else            c = CMD_NONE;
    return c;
  endfunction

endpackage

// File: rtl/lap_timer_core_if.sv
// Control and status bundle of the lap timer.
//   master : drives tick/commands/edits/lap requests, observes time and laps
//   slave  : the timer core
interface lap_timer_core_if #(
  parameter int MIN_W     = 6,
  parameter int SEC_W     = 6,
  parameter int LAP_DEPTH = 4
);
  localparam int CNT_W = $clog2(LAP_DEPTH + 1);

  logic             tick;
  logic             start;
  logic             stop;
  logic             clear;
  logic             mode_down;
  logic             inc_min;
  logic             inc_sec;
  logic             dec;
  logic             lap;
  logic             lap_rd;
  logic [MIN_W-1:0] minutes;
  logic [SEC_W-1:0] seconds;
  logic             running;
  logic             expired;
  logic             blink;
  logic             lap_valid;
  logic [MIN_W-1:0] lap_min;
  logic [SEC_W-1:0] lap_sec;
  logic [CNT_W-1:0] lap_count;
  logic             lap_overflow;

  modport master (
    output tick, start, stop, clear, mode_down, inc_min, inc_sec, dec, lap, lap_rd,
    input  minutes, seconds, running, expired, blink,
    input  lap_valid, lap_min, lap_sec, lap_count, lap_overflow
  );

  modport slave (
    input  tick, start, stop, clear, mode_down, inc_min, inc_sec, dec, lap, lap_rd,
    output minutes, seconds, running, expired, blink,
    output lap_valid, lap_min, lap_sec, lap_count, lap_overflow
  );

endinterface

// File: rtl/lap_fifo.sv
// Synchronous first-word-fall-through FIFO for captured lap times.
//   clk, rst : clock, asynchronous active-high reset
//   flush    : empties the FIFO (wins over push/pop)
//   push/din : write request and data; dropped when full unless popping too
//   pop      : remove head; ignored while empty
//   dout     : registered head entry (zero while empty)
//   count    : entries held; full/empty status
module lap_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next, rd_ptr_inc;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0] head_reg, head_next;
  logic             empty_reg;
  logic             is_empty, is_full, do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign is_empty   = (count_reg == '0);
  assign is_full    = (count_reg == CNT_W'(DEPTH));
  assign do_pop     = pop && !is_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
  assign do_push    = push && (!is_full || do_pop);
  assign rd_ptr_inc = ptr_inc(rd_ptr_reg);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] entry_reg;
    always_ff @(posedge clk) begin
      if (do_push && !flush && wr_ptr_reg == PTR_W'(gi))
        entry_reg <= din;
    end
    assign mem[gi] = entry_reg;
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    head_next   = head_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
      head_next   = '0;
    end else begin
      if (do_push) wr_ptr_next = ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_next = rd_ptr_inc;
      if (do_push && !do_pop)      count_next = count_reg + 1'b1;
      else if (do_pop && !do_push) count_next = count_reg - 1'b1;
      // The head is a registered read; the new head is either the incoming
      // word (FIFO was empty or only the popped word was held) or the entry
      // behind the popped one, which is already stored.
      if (count_next == '0)
        head_next = '0;
      else if (is_empty)
        head_next = din;
      else if (do_pop)
        head_next = (count_reg == CNT_W'(1)) ? din : mem[rd_ptr_inc];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
      empty_reg  <= 1'b1;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
      empty_reg  <= (count_next == '0);
    end
  end

  assign dout  = head_reg;
  assign count = count_reg;
  assign full  = is_full;
  assign empty = empty_reg;

endmodule

// File: rtl/lap_timer_core.sv
// Stopwatch / countdown engine advancing on an external tick strobe.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : slave side of lap_timer_core_if
//     inputs  tick, start, stop, clear, mode_down, inc_min, inc_sec, dec,
//             lap, lap_rd
//     outputs minutes, seconds, running, expired, blink, lap_valid,
//             lap_min, lap_sec, lap_count, lap_overflow (all registered)
module lap_timer_core
  import lap_timer_pkg::*;
#(
  parameter int MIN_W       = 6,
  parameter int SEC_W       = 6,
  parameter int MIN_MAX     = 59,
  parameter int SEC_MAX     = 59,
  parameter int TICK_DIV    = 1000,
  parameter int BLINK_TICKS = 500,
  parameter int LAP_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           rst,
  lap_timer_core_if.slave bus
);

  localparam int SUB_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int CNT_W = $clog2(LAP_DEPTH + 1);
  localparam logic [MIN_W-1:0] MIN_TOP  = MIN_W'(MIN_MAX);
  localparam logic [SEC_W-1:0] SEC_TOP  = SEC_W'(SEC_MAX);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICK_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);

  timer_state_t     state_reg, state_next;
  logic [MIN_W-1:0] min_reg, min_next;
  logic [SEC_W-1:0] sec_reg, sec_next;
  logic [SUB_W-1:0] sub_reg, sub_next;
  logic [BLK_W-1:0] blink_cnt_reg, blink_cnt_next;
  logic             blink_reg, blink_next;
  logic             dir_reg, dir_next;
  logic             running_reg, running_next;
  logic             expired_reg, expired_next;
  logic             overflow_reg, overflow_next;

  cmd_t             cmd;
  logic             start_ok, edit_ok, tick_run, step, step_expire;
  logic             at_top, at_zero, at_one;
  logic             lap_push, lap_full, lap_empty;
  logic [CNT_W-1:0] lap_cnt;
  logic [MIN_W+SEC_W-1:0] lap_head;

  assign cmd     = resolve_cmd(bus.clear, bus.stop, bus.start, bus.inc_min | bus.inc_sec);
  assign at_top  = (min_reg == MIN_TOP) && (sec_reg == SEC_TOP);
  assign at_zero = (min_reg == '0) && (sec_reg == '0);
  assign at_one  = (min_reg == '0) && (sec_reg == SEC_W'(1));

  // A down-mode start from 00:00 in IDLE would expire instantly, so it is refused.
  assign start_ok = (cmd == CMD_START) &&
                    (((state_reg == IDLE) && !(bus.mode_down && at_zero)) ||
                     (state_reg == PAUSED));
  assign edit_ok  = (cmd == CMD_EDIT) && (state_reg != RUN);
  // A stop or clear freezes the count in the cycle it is accepted.
  assign tick_run = (state_reg == RUN) && bus.tick &&
                    (cmd != CMD_STOP) && (cmd != CMD_CLEAR);
  assign step     = tick_run && (sub_reg == SUB_LAST);
  // Up: the step out of the top value saturates. Down: the step landing on
  // 00:00 expires; a step starting at 00:00 (reachable by editing while
  // paused) holds there and expires as well.
  assign step_expire = step && (dir_reg ? (at_zero || at_one) : at_top);

  assign lap_push = bus.lap && (state_reg == RUN) && (cmd != CMD_CLEAR);

  lap_fifo #(
    .WIDTH (MIN_W + SEC_W),
    .DEPTH (LAP_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (cmd == CMD_CLEAR),
    .push  (lap_push),
    .pop   (bus.lap_rd),
    .din   ({min_reg, sec_reg}),
    .dout  (lap_head),
    .count (lap_cnt),
    .full  (lap_full),
    .empty (lap_empty)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok) state_next = RUN;
      RUN: begin
        if (cmd == CMD_CLEAR)     state_next = IDLE;
        else if (cmd == CMD_STOP) state_next = PAUSED;
        else if (step_expire)     state_next = EXPIRED;
      end
      PAUSED: begin
        if (cmd == CMD_CLEAR) state_next = IDLE;
        else if (start_ok)    state_next = RUN;
      end
      EXPIRED: begin
        if (cmd == CMD_CLEAR || cmd == CMD_STOP || cmd == CMD_EDIT)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Timekeeping datapath: sub-tick divider, time step and edits
  always_comb begin
    min_next = min_reg;
    sec_next = sec_reg;
    sub_next = sub_reg;
    dir_next = dir_reg;
    if (cmd == CMD_CLEAR) begin
      min_next = '0;
      sec_next = '0;
      sub_next = '0;
    end else begin
      if (start_ok) dir_next = bus.mode_down;
      if (tick_run) begin
        if (sub_reg == SUB_LAST) begin
          sub_next = '0;
          if (!dir_reg) begin
            if (!at_top) begin
              if (sec_reg == SEC_TOP) begin
                sec_next = '0;
                min_next = min_reg + 1'b1;
              end else begin
                sec_next = sec_reg + 1'b1;
              end
            end
          end else if (!at_zero) begin
            if (sec_reg == '0) begin
              sec_next = SEC_TOP;
              min_next = min_reg - 1'b1;
            end else begin
              sec_next = sec_reg - 1'b1;
            end
          end
        end else begin
          sub_next = sub_reg + 1'b1;
        end
      end
      // Edit fields wrap independently; seconds never carry into minutes.
      if (edit_ok && bus.inc_min) begin
        if (bus.dec) min_next = (min_reg == '0) ? MIN_TOP : min_reg - 1'b1;
        else         min_next = (min_reg == MIN_TOP) ? '0 : min_reg + 1'b1;
      end
      if (edit_ok && bus.inc_sec) begin
        if (bus.dec) sec_next = (sec_reg == '0) ? SEC_TOP : sec_reg - 1'b1;
        else         sec_next = (sec_reg == SEC_TOP) ? '0 : sec_reg + 1'b1;
      end
    end
  end

  // Output logic (values registered below)
  always_comb begin
    running_next   = (state_next == RUN);
    expired_next   = (state_next == EXPIRED);
    blink_next     = 1'b0;
    blink_cnt_next = '0;
    if (state_next == EXPIRED) begin
      if (state_reg != EXPIRED) begin
        blink_next = 1'b1;
      end else begin
        blink_next     = blink_reg;
        blink_cnt_next = blink_cnt_reg;
        if (bus.tick) begin
          if (blink_cnt_reg == BLK_LAST) begin
            blink_cnt_next = '0;
            blink_next     = !blink_reg;
          end else begin
            blink_cnt_next = blink_cnt_reg + 1'b1;
          end
        end
      end
    end
    overflow_next = overflow_reg;
    if (cmd == CMD_CLEAR)
      overflow_next = 1'b0;
    else if (lap_push && lap_full && !bus.lap_rd)
      overflow_next = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_reg       <= '0;
      sec_reg       <= '0;
      sub_reg       <= '0;
      dir_reg       <= 1'b0;
      blink_reg     <= 1'b0;
      blink_cnt_reg <= '0;
      running_reg   <= 1'b0;
      expired_reg   <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      min_reg       <= min_next;
      sec_reg       <= sec_next;
      sub_reg       <= sub_next;
      dir_reg       <= dir_next;
      blink_reg     <= blink_next;
      blink_cnt_reg <= blink_cnt_next;
      running_reg   <= running_next;
      expired_reg   <= expired_next;
      overflow_reg  <= overflow_next;
    end
  end

  assign bus.minutes      = min_reg;
  assign bus.seconds      = sec_reg;
  assign bus.running      = running_reg;
  assign bus.expired      = expired_reg;
  assign bus.blink        = blink_reg;
  assign bus.lap_valid    = !lap_empty;
  assign bus.lap_min      = lap_head[MIN_W+SEC_W-1:SEC_W];
  assign bus.lap_sec      = lap_head[SEC_W-1:0];
  assign bus.lap_count    = lap_cnt;
  assign bus.lap_overflow = overflow_reg;

endmodule

// File: tb/tb_lap_timer_core.sv
// Self-checking bench for lap_timer_core: a reference model kept in total
// seconds with a queue of lap captures, directed scenarios with literal
// expectations, then a randomized run compared every cycle.
module tb_lap_timer_core;

  localparam int TICK_DIV = 4;
  localparam int BLINK    = 2;
  localparam int DEPTH    = 4;
  localparam int RADIX    = 60;
  localparam int TOP_T    = 59 * 60 + 59;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_EXP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  lap_timer_core_if #(.MIN_W(6), .SEC_W(6), .LAP_DEPTH(DEPTH)) bus ();

  lap_timer_core #(
    .MIN_W(6), .SEC_W(6), .MIN_MAX(59), .SEC_MAX(59),
    .TICK_DIV(TICK_DIV), .BLINK_TICKS(BLINK), .LAP_DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- reference model ----------------
  int m_t = 0;
  int m_phase = 0;
  int m_state = S_IDLE;
  bit m_dir = 0;
  bit m_blink = 0;
  int m_bcnt = 0;
  bit m_ovf = 0;
  int m_q[$];

  task automatic model_reset();
    m_t = 0; m_phase = 0; m_state = S_IDLE; m_dir = 0;
    m_blink = 0; m_bcnt = 0; m_ovf = 0; m_q.delete();
  endtask

  task automatic apply_edit();
    int mm, ss;
    mm = m_t / RADIX;
    ss = m_t % RADIX;
    if (bus.inc_min) mm = bus.dec ? (mm + 59) % 60 : (mm + 1) % 60;
    if (bus.inc_sec) ss = bus.dec ? (ss + 59) % 60 : (ss + 1) % 60;
    m_t = mm * RADIX + ss;
  endtask

  task automatic model_step();
    int cmd, ns;
    cmd = bus.clear ? 4 : bus.stop ? 3 : bus.start ? 2 :
          (bus.inc_min || bus.inc_sec) ? 1 : 0;
    ns = m_state;
    if (cmd == 4) begin
      ns = S_IDLE; m_t = 0; m_phase = 0; m_q.delete(); m_ovf = 0;
    end else begin
      if (bus.lap_rd && m_q.size() > 0) void'(m_q.pop_front());
      if (bus.lap && m_state == S_RUN) begin
        if (m_q.size() < DEPTH) m_q.push_back(m_t);
        else m_ovf = 1;
      end
      case (m_state)
        S_IDLE: begin
          if (cmd == 2) begin
            if (!(bus.mode_down && m_t == 0)) begin ns = S_RUN; m_dir = bus.mode_down; end
          end else if (cmd == 1) apply_edit();
        end
        S_RUN: begin
          if (cmd == 3) ns = S_PAUSED;
          else if (bus.tick) begin
            m_phase++;
            if (m_phase == TICK_DIV) begin
              m_phase = 0;
              if (!m_dir) begin
                if (m_t == TOP_T) ns = S_EXP; else m_t++;
              end else begin
                if (m_t == 0) ns = S_EXP;
                else begin m_t--; if (m_t == 0) ns = S_EXP; end
              end
            end
          end
        end
        S_PAUSED: begin
          if (cmd == 2) begin ns = S_RUN; m_dir = bus.mode_down; end
          else if (cmd == 1) apply_edit();
        end
        default: begin
          if (cmd == 3) ns = S_IDLE;
          else if (cmd == 1) begin apply_edit(); ns = S_IDLE; end
        end
      endcase
    end
    if (ns == S_EXP) begin
      if (m_state != S_EXP) begin m_blink = 1; m_bcnt = 0; end
      else if (bus.tick) begin
        m_bcnt++;
        if (m_bcnt == BLINK) begin m_bcnt = 0; m_blink = !m_blink; end
      end
    end else begin
      m_blink = 0; m_bcnt = 0;
    end
    m_state = ns;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("minutes", bus.minutes, m_t / RADIX);
    chk("seconds", bus.seconds, m_t % RADIX);
    chk("running", bus.running, m_state == S_RUN);
    chk("expired", bus.expired, m_state == S_EXP);
    chk("blink", bus.blink, m_blink);
    chk("lap_valid", bus.lap_valid, m_q.size() != 0);
    chk("lap_count", bus.lap_count, m_q.size());
    chk("lap_overflow", bus.lap_overflow, m_ovf);
    if (m_q.size() != 0) begin
      chk("lap_min", bus.lap_min, m_q[0] / RADIX);
      chk("lap_sec", bus.lap_sec, m_q[0] % RADIX);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      compare_all();
    end
  end

  // Literal time expectation, applied to both the DUT and the model.
  task automatic lit_time(string name, int mm, int ss);
    chk({name, "_min"}, bus.minutes, mm);
    chk({name, "_sec"}, bus.seconds, ss);
    chk({name, "_model"}, m_t, mm * RADIX + ss);
  endtask

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
    bus.tick = 0; bus.start = 0; bus.stop = 0; bus.clear = 0;
    bus.inc_min = 0; bus.inc_sec = 0; bus.lap = 0; bus.lap_rd = 0;
  endtask

  task automatic do_ticks(int n);
    repeat (n) begin
      bus.tick = 1; cyc();
      cyc();
    end
  endtask

  initial begin
    bus.tick = 0; bus.start = 0; bus.stop = 0; bus.clear = 0; bus.mode_down = 0;
    bus.inc_min = 0; bus.inc_sec = 0; bus.dec = 0; bus.lap = 0; bus.lap_rd = 0;
    repeat (3) @(posedge clk);
    #1;
    lit_time("reset", 0, 0);
    chk("reset_running", bus.running, 0);
    chk("reset_lap_count", bus.lap_count, 0);
    rst = 0;
    cyc();

    // Edits with wrap, seconds do not carry
    bus.dec = 1; bus.inc_min = 1; cyc(); lit_time("edit_min_dn", 59, 0);
    bus.inc_sec = 1; cyc();              lit_time("edit_sec_dn", 59, 59);
    bus.dec = 0; bus.inc_sec = 1; cyc(); lit_time("edit_sec_up", 59, 0);

    // Up count with carry
    bus.clear = 1; cyc();
    bus.dec = 1; bus.inc_sec = 1; cyc(); bus.inc_sec = 1; cyc(); bus.dec = 0;
    lit_time("preset58", 0, 58);
    bus.mode_down = 0; bus.start = 1; cyc();
    do_ticks(4); lit_time("up1", 0, 59);
    do_ticks(4); lit_time("up2", 1, 0);
    do_ticks(4); lit_time("up3", 1, 1);

    // Saturation at the top
    bus.stop = 1; cyc(); bus.clear = 1; cyc();
    bus.dec = 1; bus.inc_min = 1; cyc(); bus.inc_sec = 1; cyc(); bus.dec = 0;
    bus.start = 1; cyc();
    do_ticks(4); lit_time("sat", 59, 59);
    chk("sat_expired", bus.expired, 1);
    chk("sat_blink", bus.blink, 1);

    // Countdown with borrow, expiry and blink
    bus.clear = 1; cyc();
    bus.inc_min = 1; cyc();
    bus.mode_down = 1; bus.start = 1; cyc();
    do_ticks(4); lit_time("down1", 0, 59);
    bus.stop = 1; cyc(); bus.clear = 1; cyc();
    bus.inc_sec = 1; cyc();
    bus.start = 1; cyc();
    do_ticks(4); lit_time("down_zero", 0, 0);
    chk("down_expired", bus.expired, 1);
    chk("blink_a", bus.blink, 1);
    do_ticks(2); chk("blink_b", bus.blink, 0);
    do_ticks(2); chk("blink_c", bus.blink, 1);
    bus.start = 1; cyc(); chk("exp_start_ignored", bus.expired, 1);
    bus.stop = 1; cyc();  chk("exp_stop_blink", bus.blink, 0);
    bus.start = 1; cyc(); chk("zero_start_ignored", bus.running, 0);
    bus.mode_down = 0;

    // Edits ignored in RUN
    bus.start = 1; cyc(); chk("run_started", bus.running, 1);
    bus.inc_sec = 1; cyc(); lit_time("run_edit", 0, 0);

    // Pause keeps the sub-tick count
    do_ticks(2);
    bus.stop = 1; cyc();
    do_ticks(10);
    bus.start = 1; cyc();
    do_ticks(1); lit_time("resume1", 0, 0);
    do_ticks(1); lit_time("resume2", 0, 1);

    // Laps: overflow and simultaneous push/pop when full
    for (int i = 0; i < 5; i++) begin
      bus.lap = 1; cyc();
      do_ticks(4);
    end
    chk("lap_full_count", bus.lap_count, 4);
    chk("lap_ovf", bus.lap_overflow, 1);
    chk("lap_head_first", bus.lap_sec, 1);
    bus.lap = 1; bus.lap_rd = 1; cyc();
    chk("lap_pp_count", bus.lap_count, 4);
    chk("lap_pp_ovf", bus.lap_overflow, 1);
    chk("lap_pp_head", bus.lap_sec, 2);
    repeat (4) begin bus.lap_rd = 1; cyc(); end
    chk("lap_drained", bus.lap_valid, 0);

    // clear beats start
    bus.lap = 1; cyc(); bus.lap = 1; cyc();
    bus.clear = 1; bus.start = 1; cyc();
    chk("clr_running", bus.running, 0);
    lit_time("clr", 0, 0);
    chk("clr_laps", bus.lap_count, 0);

    // Asynchronous reset mid-run
    bus.start = 1; cyc();
    do_ticks(5);
    bus.lap = 1; cyc();
    rst = 1;
    @(negedge clk);
    lit_time("rst_mid", 0, 0);
    chk("rst_mid_laps", bus.lap_count, 0);
    chk("rst_mid_running", bus.running, 0);
    @(posedge clk); #1; rst = 0;
    cyc();

    // Randomized run
    for (int n = 0; n < 4000; n++) begin
      bus.tick    = ($urandom % 2) == 0;
      bus.start   = ($urandom % 16) == 0;
      bus.stop    = ($urandom % 40) == 0;
      bus.clear   = ($urandom % 300) == 0;
      bus.inc_min = ($urandom % 25) == 0;
      bus.inc_sec = ($urandom % 12) == 0;
      bus.dec     = ($urandom % 2) == 0;
      if (($urandom % 64) == 0) bus.mode_down = !bus.mode_down;
      bus.lap     = ($urandom % 6) == 0;
      bus.lap_rd  = ($urandom % 5) == 0;
      cyc();
    end
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lap_timer_core.md
Name: lap_timer_core

Overview:
Parametrised stopwatch/countdown engine that replaces the fixed 59:59 timer core. It runs on the 100 MHz system clock and advances on an external 1-cycle tick strobe (the 1 kHz enable). It supports count-up and count-down modes, edit wrap in both directions, a saturating or expiring end-of-count, an expiry blink, and a lap-capture FIFO with a read handshake. Its outputs feed display_driver and blinking_display directly.

Parameters:
MIN_W, 6, width of the minutes field
SEC_W, 6, width of the seconds field
MIN_MAX, 59, largest minutes value (must be < 2**MIN_W)
SEC_MAX, 59, largest seconds value (must be < 2**SEC_W)
TICK_DIV, 1000, tick strobes per second
BLINK_TICKS, 500, tick strobes per blink half-period
LAP_DEPTH, 4, lap FIFO entries (≥ 2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
tick  in  1  one-cycle enable at tick rate
start  in  1  one-cycle pulse, begin/resume counting
stop  in  1  one-cycle pulse, pause
clear  in  1  one-cycle pulse, soft reset of time and laps
mode_down  in  1  0 = count up, 1 = count down
inc_min  in  1  one-cycle pulse, edit minutes
inc_sec  in  1  one-cycle pulse, edit seconds
dec  in  1  edit direction, 1 = decrement
lap  in  1  one-cycle pulse, capture current time
lap_rd  in  1  pop the FIFO head
minutes  out  MIN_W  current minutes
seconds  out  SEC_W  current seconds
running  out  1  high in RUN
expired  out  1  high in EXPIRED
blink  out  1  expiry blink enable
lap_valid  out  1  FIFO not empty
lap_min  out  MIN_W  head entry minutes (first-word fall-through)
lap_sec  out  SEC_W  head entry seconds
lap_count  out  $clog2(LAP_DEPTH+1)  number of entries held
lap_overflow  out  1  sticky, a lap was dropped

Behaviour:
- Reset: state IDLE; minutes/seconds 0; sub-tick counter 0; blink 0; FIFO empty; lap_overflow 0; direction latch 0. All outputs are registered.
- Command priority within one cycle: clear > stop > start > edits.
- States:
  - IDLE: start goes to RUN, except in down mode at 00:00, where start is ignored.
  - RUN: stop goes to PAUSED, keeping time and the sub-tick counter.
  - PAUSED: start goes to RUN and resumes from the retained sub-tick count.
  - EXPIRED: stop goes to IDLE keeping time; start is ignored.
  - clear from any state: IDLE, time 00:00, sub-tick counter 0, FIFO flushed, lap_overflow cleared.
- Direction: mode_down is latched on the cycle start is accepted. Changes to mode_down during RUN have no effect.
- Edits (IDLE, PAUSED, EXPIRED only; ignored in RUN):
  - Minutes: up wraps MIN_MAX→0; down wraps 0→MIN_MAX.
  - Seconds: same wrap rules within 0..SEC_MAX, with no carry into minutes.
  - An edit in EXPIRED also moves the block to IDLE.
- Counting (RUN):
  - Each tick increments the sub-tick counter.
  - A tick while the counter is at TICK_DIV-1 resets it to 0 and steps time once. minutes/seconds update in the cycle after that tick.
  - Up mode: seconds SEC_MAX→0 carries into minutes. At MIN_MAX:SEC_MAX the value holds (saturates) and the state goes to EXPIRED.
  - Down mode: seconds 0→SEC_MAX borrows from minutes. The step that reaches 00:00 also enters EXPIRED in the same update.
- Blink:
  - 0 outside EXPIRED.
  - On entry to EXPIRED: blink = 1 and the blink tick counter is 0. blink toggles after every BLINK_TICKS ticks.
  - Leaving EXPIRED forces blink to 0 on the next cycle.
- Laps:
  - lap in RUN pushes the pre-update {minutes, seconds} of that cycle. lap in other states is ignored.
  - Push when full: the entry is dropped and lap_overflow is set.
  - lap_rd while lap_valid pops the head. lap_rd while empty is ignored.
  - Push and pop in the same cycle when full: both succeed, count is unchanged, no overflow.
  - Push and pop in the same cycle when empty: the push succeeds, the pop is ignored.
  - lap_count, lap_valid and the head outputs update one cycle after the push or pop.
- Reset asserted mid-count returns immediately to the reset values, with no partial update.

Decomposition:
- lap_timer_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} timer_state_t
  - the command-priority constants
- One sub-module, lap_fifo: parametrised width/depth, synchronous FIFO with first-word fall-through, count/full/empty outputs, and the simultaneous push-pop-when-full rule above.
- All timekeeping stays in lap_timer_core.

Test Plan:
Test benches use TICK_DIV=4, BLINK_TICKS=2, LAP_DEPTH=4.
- Up wrap: up mode, preset 00:58, start, 12 ticks → 00:59, then 01:00, then 01:01. At preset 59:59 plus 4 ticks: holds 59:59, expired=1, blink=1.
- Countdown: preset 01:00, mode_down=1, start, 4 ticks → 00:59. Preset 00:01 plus 4 ticks → 00:00 with expired=1. Then blink toggles every 2 ticks (1,0,1). start while at 00:00 is ignored.
- Edits: IDLE at 00:00, dec=1 inc_min → 59:00. dec=1 inc_sec → 59:59. dec=0 inc_sec → 59:00 (no carry). inc_sec during RUN → no change.
- Pause/resume: stop after 2 ticks of a second, then 10 idle ticks, then start. The step occurs after exactly 2 further ticks.
- Laps: 5 lap pulses in RUN → lap_count=4, lap_overflow=1. Heads pop in capture order. lap+lap_rd in the same cycle when full → count stays 4, overflow unchanged.
- Priority/reset: clear+start in the same cycle → IDLE, 00:00, FIFO empty. rst pulse mid-RUN → all outputs 0 while rst is high.
